// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : opcode encodings and FSM state type for alu_seq_core        |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_EQ   = 4'hA;
  localparam logic [3:0] OP_GT   = 4'hB;
  localparam logic [3:0] OP_SHR  = 4'hC;
  localparam logic [3:0] OP_SHL  = 4'hD;
  // Any opcode at or above this value (including nonzero extra MSBs) is illegal.
  localparam logic [3:0] OP_ILL_LO = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_div_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_div_seq : restoring divider, one quotient bit per clock           |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module alu_div_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] diff;
  logic              ge;

  // Dividend shifts out of quot MSB-first while quotient bits shift in at the LSB.
  always_comb begin
    trial = {rem_q, quot_q[DATA_W-1]};
    ge    = (trial >= {1'b0, b_q});
    diff  = trial[DATA_W-1:0] - b_q;

    rem_d  = rem_q;
    quot_d = quot_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (start) begin
      rem_d  = '0;
      quot_d = a;
      b_d    = b;
      cnt_d  = CNT_INIT;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = ge ? diff : trial[DATA_W-1:0];
      quot_d = {quot_q[DATA_W-2:0], ge};
      cnt_d  = cnt_q - CNT_LAST;
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;

endmodule
`default_nettype wire

// File: rtl/alu_seq_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_seq_core : handshaked ALU with registered results and seq. divide |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 2 * DATA_W,
  parameter int FUN_W  = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              Enable,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [FUN_W-1:0]  ALU_FUN,
  output logic [OUT_W-1:0]  ALU_OUT,
  output logic              OUT_VALID,
  output logic              CARRY,
  output logic              ZERO,
  output logic              DIV0,
  output logic              ERR
);

  alu_state_t        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [FUN_W-1:0]  fun_q, fun_d;
  logic [OUT_W-1:0]  alu_out_q, alu_out_d;
  logic              out_valid_q, out_valid_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              div0_q, div0_d;
  logic              err_q, err_d;

  logic              accept;
  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [DATA_W-1:0] div_quot;
  logic [DATA_W-1:0] div_rem;

  logic [OUT_W-1:0]  op_res;
  logic              op_carry;
  logic              op_div0;
  logic              op_err;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W-1:0] logic_res;

  assign IN_READY = (state_q == ST_IDLE) && Enable;
  assign accept   = IN_VALID && IN_READY;

  alu_div_seq #(
    .DATA_W (DATA_W)
  ) u_div (
    .clk   (clk),
    .rst_n (RST),
    .start (div_start),
    .a     (A),
    .b     (B),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot),
    .rem   (div_rem)
  );

  // Single-cycle operations on the captured operands; DIV here only ever means B==0.
  always_comb begin
    sum_w     = {1'b0, a_q} + {1'b0, b_q};
    logic_res = '0;
    op_res    = '0;
    op_carry  = 1'b0;
    op_div0   = 1'b0;
    op_err    = 1'b0;
    case (fun_q)
      FUN_W'(OP_ADD): begin
        op_res   = OUT_W'(sum_w);
        op_carry = sum_w[DATA_W];
      end
      FUN_W'(OP_SUB): begin
        op_res   = OUT_W'(a_q) - OUT_W'(b_q);
        op_carry = (a_q < b_q);
      end
      FUN_W'(OP_MUL): op_res = OUT_W'(a_q) * OUT_W'(b_q);
      FUN_W'(OP_DIV): begin
        op_res  = OUT_W'({DATA_W{1'b1}});
        op_div0 = 1'b1;
      end
      FUN_W'(OP_AND):  begin logic_res = a_q & b_q;    op_res = OUT_W'(logic_res); end
      FUN_W'(OP_OR):   begin logic_res = a_q | b_q;    op_res = OUT_W'(logic_res); end
      FUN_W'(OP_NAND): begin logic_res = ~(a_q & b_q); op_res = OUT_W'(logic_res); end
      FUN_W'(OP_NOR):  begin logic_res = ~(a_q | b_q); op_res = OUT_W'(logic_res); end
      FUN_W'(OP_XOR):  begin logic_res = a_q ^ b_q;    op_res = OUT_W'(logic_res); end
      FUN_W'(OP_XNOR): begin logic_res = ~(a_q ^ b_q); op_res = OUT_W'(logic_res); end
      FUN_W'(OP_EQ):   op_res = OUT_W'(a_q == b_q);
      FUN_W'(OP_GT):   op_res = OUT_W'(a_q > b_q);
      FUN_W'(OP_SHR):  begin logic_res = a_q >> 1; op_res = OUT_W'(logic_res); end
      FUN_W'(OP_SHL):  op_res = OUT_W'({a_q, 1'b0});
      default: begin
        op_res = '0;
        op_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    fun_d       = fun_q;
    alu_out_d   = alu_out_q;
    out_valid_d = 1'b0;
    carry_d     = carry_q;
    zero_d      = zero_q;
    div0_d      = div0_q;
    err_d       = err_q;
    div_start   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d   = A;
          b_d   = B;
          fun_d = ALU_FUN;
          if ((ALU_FUN == FUN_W'(OP_DIV)) && (B != '0)) begin
            div_start = 1'b1;
            state_d   = ST_DIV;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        alu_out_d   = op_res;
        carry_d     = op_carry;
        zero_d      = (op_res == '0);
        div0_d      = op_div0;
        err_d       = op_err;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DIV: begin
        if (div_done && !div_busy) begin
          alu_out_d   = OUT_W'({div_rem, div_quot});
          carry_d     = 1'b0;
          zero_d      = ({div_rem, div_quot} == '0);
          div0_d      = 1'b0;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      alu_out_q   <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      div0_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      alu_out_q   <= alu_out_d;
      out_valid_q <= out_valid_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      div0_q      <= div0_d;
      err_q       <= err_d;
    end
  end

  assign ALU_OUT   = alu_out_q;
  assign OUT_VALID = out_valid_q;
  assign CARRY     = carry_q;
  assign ZERO      = zero_q;
  assign DIV0      = div0_q;
  assign ERR       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_seq_core : randomized + directed bench with arithmetic model   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_alu_seq_core;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        Enable = 1'b1;
  logic        IN_VALID = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [3:0]  ALU_FUN = '0;
  logic        IN_READY;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID, CARRY, ZERO, DIV0, ERR;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_out = '0;
  logic        exp_c = 1'b0, exp_z = 1'b0, exp_d0 = 1'b0, exp_e = 1'b0;

  always #5 clk = ~clk;

  alu_seq_core #(
    .DATA_W (8),
    .OUT_W  (16),
    .FUN_W  (4)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .Enable    (Enable),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .ALU_FUN   (ALU_FUN),
    .ALU_OUT   (ALU_OUT),
    .OUT_VALID (OUT_VALID),
    .CARRY     (CARRY),
    .ZERO      (ZERO),
    .DIV0      (DIV0),
    .ERR       (ERR)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour written from the opcode table with plain integer math.
  task automatic model(input int a, input int b, input int fun, output int lat);
    int r;
    exp_c = 0; exp_d0 = 0; exp_e = 0; lat = 2;
    case (fun)
      0:  begin r = a + b; exp_c = (r > 255); end
      1:  begin r = (a - b) & 16'hFFFF; exp_c = (a < b); end
      2:  r = a * b;
      3:  if (b == 0) begin r = 255; exp_d0 = 1; end
          else begin r = (a % b) * 256 + (a / b); lat = 10; end
      4:  r = a & b;
      5:  r = a | b;
      6:  r = (~(a & b)) & 255;
      7:  r = (~(a | b)) & 255;
      8:  r = a ^ b;
      9:  r = (~(a ^ b)) & 255;
      10: r = (a == b) ? 1 : 0;
      11: r = (a > b) ? 1 : 0;
      12: r = a / 2;
      13: r = a * 2;
      default: begin r = 0; exp_e = 1; end
    endcase
    exp_out = 16'(r);
    exp_z   = (r == 0);
  endtask

  // Called at a negedge with the core idle; returns at a negedge with it idle again.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun,
                        input bit hold, input bit drop_en);
    int lat, exp_lat;
    model(int'(a), int'(b), int'(fun), exp_lat);
    A = a; B = b; ALU_FUN = fun; IN_VALID = 1'b1;
    #1 check_eq("ready_idle", 32'(IN_READY), 1);
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check_eq("ready_busy", 32'(IN_READY), 0);
        if (!hold) IN_VALID = 1'b0;
        if (drop_en) Enable = 1'b0;
      end
      if (OUT_VALID) begin
        lat = k;
        break;
      end
    end
    check_eq($sformatf("latency op%0h", fun), 32'(lat), 32'(exp_lat));
    check_eq($sformatf("out op%0h a%0h b%0h", fun, a, b), 32'(ALU_OUT), 32'(exp_out));
    check_eq("carry", 32'(CARRY), 32'(exp_c));
    check_eq("zero", 32'(ZERO), 32'(exp_z));
    check_eq("div0", 32'(DIV0), 32'(exp_d0));
    check_eq("err", 32'(ERR), 32'(exp_e));
    @(negedge clk);
    IN_VALID = 1'b0;
    Enable   = 1'b1;
    check_eq("pulse_one_cycle", 32'(OUT_VALID), 0);
    check_eq("out_held", 32'(ALU_OUT), 32'(exp_out));
  endtask

  task automatic count_ov(input int cycles, output int seen);
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (OUT_VALID) seen++;
    end
  endtask

  initial begin
    int seen;
    logic [7:0] ra, rb;
    logic [3:0] rf;

    #1 RST = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_out", 32'(ALU_OUT), 0);
    check_eq("rst_valid", 32'(OUT_VALID), 0);
    check_eq("rst_flags", {28'd0, CARRY, ZERO, DIV0, ERR}, 0);
    check_eq("rst_ready", 32'(IN_READY), 1);
    RST = 1'b1;
    @(negedge clk);

    run_op(8'hFF, 8'h01, 4'h0, 0, 0);

    // Abort a divide part-way through with an asynchronous reset.
    A = 8'd200; B = 8'd3; ALU_FUN = 4'h3; IN_VALID = 1'b1;
    @(posedge clk);
    @(negedge clk);
    IN_VALID = 1'b0;
    repeat (3) @(negedge clk);
    #2 RST = 1'b0;
    #1;
    check_eq("midrst_out", 32'(ALU_OUT), 0);
    check_eq("midrst_valid", 32'(OUT_VALID), 0);
    check_eq("midrst_carry", 32'(CARRY), 0);
    @(negedge clk);
    RST = 1'b1;
    @(negedge clk);
    check_eq("midrst_ready", 32'(IN_READY), 1);
    count_ov(14, seen);
    check_eq("midrst_no_valid", 32'(seen), 0);

    run_op(8'd3,   8'd5,   4'h1, 0, 0);
    run_op(8'hFF,  8'hFF,  4'h2, 0, 0);
    run_op(8'd200, 8'd7,   4'h3, 0, 0);
    run_op(8'd9,   8'd0,   4'h3, 0, 0);
    run_op(8'h12,  8'h34,  4'hE, 0, 0);
    run_op(8'h5A,  8'h5A,  4'h8, 0, 0);
    run_op(8'h81,  8'h00,  4'hD, 0, 0);
    run_op(8'd7,   8'd7,   4'hA, 0, 0);

    // Request held high for the whole divide must yield exactly one result.
    run_op(8'd100, 8'd9, 4'h3, 1, 0);
    count_ov(12, seen);
    check_eq("held_single_result", 32'(seen), 0);

    // Enable dropped mid-divide: the operation still completes.
    run_op(8'd250, 8'd13, 4'h3, 0, 1);

    Enable = 1'b0; IN_VALID = 1'b1; A = 8'h11; B = 8'h22; ALU_FUN = 4'h0;
    #1 check_eq("dis_ready", 32'(IN_READY), 0);
    count_ov(6, seen);
    check_eq("dis_no_valid", 32'(seen), 0);
    check_eq("dis_out_held", 32'(ALU_OUT), 32'(exp_out));
    IN_VALID = 1'b0; Enable = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rf = 4'($urandom_range(0, 15));
      run_op(ra, rb, rf, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
